// File: rtl/fetch_pkg.sv
// Shared fetch-path definitions: NOP encoding, the {pc, instr} entry record
// and default sizing used by the prefetch queue and its interface.
package fetch_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int DEPTH_DEFAULT = 4;

    // addi x0, x0, 0 -- shown to decode whenever the queue has nothing to offer
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [XLEN_DEFAULT-1:0] instr;
    } fetch_entry_t;

    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/if_fetch_queue_if.sv
// Fetch-to-decode bundle for the prefetch queue: PC/instruction capture side,
// PC write-enable backpressure, and the decode valid/ready side.
interface if_fetch_queue_if #(
    parameter int DEPTH = fetch_pkg::DEPTH_DEFAULT,
    parameter int XLEN  = fetch_pkg::XLEN_DEFAULT
);
    localparam int CNT_W = fetch_pkg::count_width(DEPTH);

    logic [XLEN-1:0]  i_pc;
    logic [XLEN-1:0]  i_instr;
    logic             i_fetch_valid;
    logic             i_flush;
    logic             o_pc_wr_en;
    logic             o_valid;
    logic [XLEN-1:0]  o_pc;
    logic [XLEN-1:0]  o_instr;
    logic             i_ready;
    logic [CNT_W-1:0] o_count;

    // Environment side: PC/imem source plus the decode stage
    modport master (
        output i_pc, i_instr, i_fetch_valid, i_flush, i_ready,
        input  o_pc_wr_en, o_valid, o_pc, o_instr, o_count
    );

    modport slave (
        input  i_pc, i_instr, i_fetch_valid, i_flush, i_ready,
        output o_pc_wr_en, o_valid, o_pc, o_instr, o_count
    );

endinterface

// File: rtl/if_fq_storage.sv
// Entry storage for the prefetch queue: DEPTH x {pc, instr} registers with one
// synchronous write port and an asynchronous read port. Contents are not reset.
module if_fq_storage #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [2*XLEN-1:0]        wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [2*XLEN-1:0]        rdata_o
);

    logic [2*XLEN-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction prefetch queue between PC and decode, with PC backpressure and
// flush. Define IF_FETCH_QUEUE_BYPASS_EN for a zero-latency path when empty.
module if_fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int XLEN  = XLEN_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clk_en,
    if_fetch_queue_if.slave  fq
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              not_full;
    logic              stored_vld;
    logic              bypass_act;
    logic              pop;
    logic              push;
    logic              wr_push;
    logic              rd_pop;
    logic [2*XLEN-1:0] wdata;
    logic [2*XLEN-1:0] rdata;

    assign not_full   = (count_q != FULL_CNT);
    assign stored_vld = (count_q != '0);

`ifdef IF_FETCH_QUEUE_BYPASS_EN
    // Empty queue forwards the live fetch straight to decode; a redirect kills it
    assign bypass_act = !stored_vld && fq.i_fetch_valid && !fq.i_flush;
`else
    assign bypass_act = 1'b0;
`endif

    assign fq.o_valid = stored_vld || bypass_act;

    assign pop  = fq.o_valid && fq.i_ready && i_clk_en;
    assign push = fq.i_fetch_valid && i_clk_en && !fq.i_flush && (not_full || pop);

    // A bypassed entry consumed this cycle never touches the buffer
    assign rd_pop  = pop && !bypass_act;
    assign wr_push = push && !(bypass_act && pop);

    // PC advances whenever the fetched word has somewhere to go, or is being discarded
    assign fq.o_pc_wr_en = fq.i_flush || not_full || (fq.o_valid && fq.i_ready);

    assign wdata = {fq.i_pc, fq.i_instr};

    if_fq_storage #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN)
    ) u_storage (
        .clk_i   (i_clk),
        .we_i    (wr_push),
        .waddr_i (wr_ptr_q),
        .wdata_i (wdata),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata)
    );

    always_comb begin
        fq.o_pc    = '0;
        fq.o_instr = XLEN'(NOP_INSTR);
        if (stored_vld) begin
            fq.o_pc    = rdata[2*XLEN-1:XLEN];
            fq.o_instr = rdata[XLEN-1:0];
        end else if (bypass_act) begin
            fq.o_pc    = fq.i_pc;
            fq.o_instr = fq.i_instr;
        end
    end

    assign fq.o_count = count_q;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (fq.i_flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (rd_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({wr_push, rd_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Clock enable gates every update, flush included; reset overrides it
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (i_clk_en) begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue (default build): queue scoreboard of expected
// entries plus a hand-derived vector table for the fill/stall/drain case.
module tb_if_fetch_queue;
    import fetch_pkg::*;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic clk;
    logic rst;
    logic clk_en;

    int n_chk;
    int n_err;

    fetch_entry_t sb_q[$];

    if_fetch_queue_if #(.DEPTH(DEPTH), .XLEN(XLEN)) fq();

    if_fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_clk_en (clk_en),
        .fq       (fq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fv;
        logic        rdy;
        logic [31:0] pc;
        int          exp_cnt;
        logic        exp_vld;
        logic        exp_wr;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t tbl[12];

    function automatic logic [31:0] mk_instr(input logic [31:0] pc);
        return (pc << 4) ^ 32'h5A00_0033;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one cycle's inputs, then compare outputs against the scoreboard at negedge
    task automatic drive(input logic fv, input logic rdy, input logic fl,
                         input logic en, input logic r, input logic [31:0] pc);
        int          sz;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        fq.i_fetch_valid = fv;
        fq.i_ready       = rdy;
        fq.i_flush       = fl;
        fq.i_pc          = pc;
        fq.i_instr       = mk_instr(pc);
        clk_en           = en;
        rst              = r;
        @(negedge clk);
        sz      = sb_q.size();
        e_pc    = (sz > 0) ? sb_q[0].pc : 32'h0;
        e_instr = (sz > 0) ? sb_q[0].instr : NOP_INSTR;
        check("count", 32'(fq.o_count), 32'(sz));
        check("valid", 32'(fq.o_valid), 32'(sz > 0));
        check("pc_wr_en", 32'(fq.o_pc_wr_en), 32'(fl || (sz < DEPTH) || (sz > 0 && rdy)));
        check("head_pc", fq.o_pc, e_pc);
        check("head_instr", fq.o_instr, e_instr);
    endtask

    // Apply the clock edge to the scoreboard and the DUT
    task automatic advance();
        logic do_pop;
        logic do_push;
        fetch_entry_t ent;
        if (rst) begin
            sb_q.delete();
        end else if (clk_en) begin
            if (fq.i_flush) begin
                sb_q.delete();
            end else begin
                do_pop  = (sb_q.size() > 0) && fq.i_ready;
                do_push = fq.i_fetch_valid && ((sb_q.size() < DEPTH) || do_pop);
                if (do_pop) void'(sb_q.pop_front());
                if (do_push) begin
                    ent.pc    = fq.i_pc;
                    ent.instr = fq.i_instr;
                    sb_q.push_back(ent);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic fv, input logic rdy, input logic fl,
                        input logic en, input logic r, input logic [31:0] pc);
        drive(fv, rdy, fl, en, r, pc);
        advance();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0;
        n_err = 0;

        tbl[0]  = '{1'b1, 1'b0, 32'h00, 0, 1'b0, 1'b1, 32'h00};
        tbl[1]  = '{1'b1, 1'b0, 32'h04, 1, 1'b1, 1'b1, 32'h00};
        tbl[2]  = '{1'b1, 1'b0, 32'h08, 2, 1'b1, 1'b1, 32'h00};
        tbl[3]  = '{1'b1, 1'b0, 32'h0C, 3, 1'b1, 1'b1, 32'h00};
        tbl[4]  = '{1'b1, 1'b0, 32'h10, 4, 1'b1, 1'b0, 32'h00};
        tbl[5]  = '{1'b1, 1'b0, 32'h10, 4, 1'b1, 1'b0, 32'h00};
        tbl[6]  = '{1'b1, 1'b1, 32'h10, 4, 1'b1, 1'b1, 32'h00};
        tbl[7]  = '{1'b0, 1'b1, 32'h14, 4, 1'b1, 1'b1, 32'h04};
        tbl[8]  = '{1'b0, 1'b1, 32'h14, 3, 1'b1, 1'b1, 32'h08};
        tbl[9]  = '{1'b0, 1'b1, 32'h14, 2, 1'b1, 1'b1, 32'h0C};
        tbl[10] = '{1'b0, 1'b1, 32'h14, 1, 1'b1, 1'b1, 32'h10};
        tbl[11] = '{1'b0, 1'b1, 32'h14, 0, 1'b0, 1'b1, 32'h00};

        fq.i_fetch_valid = 1'b0;
        fq.i_ready       = 1'b0;
        fq.i_flush       = 1'b0;
        fq.i_pc          = '0;
        fq.i_instr       = '0;
        clk_en           = 1'b1;
        rst              = 1'b1;
        @(posedge clk);
        #1;

        // Reset state, checked while reset is still held and once released
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);

        // Streaming with ready held high
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'(i * 4));
        end
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);

        // Fill, stall, then drain with a push on the first full-pop cycle
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].fv, tbl[i].rdy, 1'b0, 1'b1, 1'b0, tbl[i].pc);
            check($sformatf("tbl%0d_count", i), 32'(fq.o_count), 32'(tbl[i].exp_cnt));
            check($sformatf("tbl%0d_valid", i), 32'(fq.o_valid), 32'(tbl[i].exp_vld));
            check($sformatf("tbl%0d_pc_wr_en", i), 32'(fq.o_pc_wr_en), 32'(tbl[i].exp_wr));
            check($sformatf("tbl%0d_pc", i), fq.o_pc, tbl[i].exp_pc);
            advance();
        end

        // Flush with three entries queued and a fetch pending
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h200);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h204);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h208);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h20C);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h100);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h104);
        check("after_flush_single", 32'(fq.o_count), 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h104);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h104);

        // Clock enable low freezes state and swallows a flush
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h300);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h304);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h308);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h308);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h308);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h308);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h308);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h308);

        // Reset while full
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'(32'h400 + i * 4));
        end
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h410);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h410);

`ifdef IF_FETCH_QUEUE_BYPASS_EN
        fq.i_fetch_valid = 1'b1;
        fq.i_ready       = 1'b1;
        fq.i_flush       = 1'b0;
        fq.i_pc          = 32'h40;
        fq.i_instr       = mk_instr(32'h40);
        clk_en           = 1'b1;
        rst              = 1'b0;
        @(negedge clk);
        check("bypass_valid", 32'(fq.o_valid), 32'd1);
        check("bypass_pc", fq.o_pc, 32'h40);
        @(posedge clk);
        #1;
        fq.i_fetch_valid = 1'b0;
        @(negedge clk);
        check("bypass_count", 32'(fq.o_count), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Instruction prefetch queue between the program counter and the decode stage. Each cycle it captures the current PC value and the instruction word returned by instruction memory for that PC, buffers them in a small FIFO, and presents them to decode through a valid/ready handshake. It is the consumer of the PC: it drives the PC write enable as backpressure, so the PC only advances when the queue can accept the fetched word. A flush input discards all buffered entries on a branch or jump redirect.

## Interface
- DEPTH, 4, number of entries; power of two, minimum 2
- XLEN, 32, PC and instruction width
- i_clk  in  1  clock; all state updates on the rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_clk_en  in  1  global stage enable; when low, no state changes
- i_pc  in  XLEN  current PC value, i.e. the PC register output
- i_instr  in  XLEN  instruction word at i_pc, from combinational instruction memory
- i_fetch_valid  in  1  i_pc/i_instr pair is valid this cycle
- i_flush  in  1  redirect; discard all entries and any push this cycle
- o_pc_wr_en  out  1  write enable to the PC register; high when this cycle's fetch is accepted or discarded
- o_valid  out  1  head entry is available to decode
- o_pc  out  XLEN  PC of the head entry
- o_instr  out  XLEN  instruction of the head entry
- i_ready  in  1  decode accepts the head entry this cycle
- o_count  out  $clog2(DEPTH)+1  number of occupied entries

## Operation
- Storage: circular buffer with read pointer, write pointer and occupancy counter. Pointers wrap modulo DEPTH.
- pop = o_valid && i_ready && i_clk_en.
- push = i_fetch_valid && i_clk_en && !i_flush && (count < DEPTH || pop).
- A push while the queue is full is accepted only if a pop happens in the same cycle. Count is then unchanged and both pointers advance.
- Count update:
  - +1 on push only
  - −1 on pop only
  - unchanged on both or neither
- o_pc_wr_en = i_flush || count < DEPTH || (o_valid && i_ready).
  - This is combinational from i_ready and i_flush.
  - It is independent of i_clk_en, because the PC register gates with its own enable.
- Flush, when i_clk_en is high:
  - count ← 0 and both pointers ← 0
  - any simultaneous push or pop is ignored
  - o_pc_wr_en is 1, so the PC loads the redirect target
- Flush has priority over push and pop. Reset has priority over everything, including when i_clk_en is low.
- o_valid = (count != 0).
- When empty: o_pc = 0 and o_instr = NOP (32'h00000013). Decode therefore never sees X values.
- Reset values:
  - count, pointers and o_count = 0
  - o_valid = 0, o_pc = 0, o_instr = NOP
  - o_pc_wr_en = 1
- The storage array is not reset. Its contents are unobservable while the queue is empty.

## Timing
- Push-to-output latency is 1 cycle: an entry pushed on edge N appears at o_valid/o_pc/o_instr after edge N.
- Steady-state throughput is 1 entry per cycle when i_ready is held high.
- When full with i_ready low, o_pc_wr_en is 0 and the PC holds. Releasing i_ready raises o_pc_wr_en in the same cycle.
- Reset asserted mid-stream empties the queue on the next edge. o_valid is 0 in the following cycle.
- While i_clk_en is low, the outputs hold their values and pointers and count are frozen. A flush is ignored in that cycle.

## Configuration
- IF_FETCH_QUEUE_BYPASS_EN defined:
  - When count == 0 and i_fetch_valid is high, o_valid = 1 with o_pc = i_pc and o_instr = i_instr combinationally.
  - If i_ready is also high, the entry is consumed directly and not written.
  - Latency becomes 0 cycles while empty.
  - Flush suppresses the bypass path: o_valid = 0 during a flush cycle.
- Undefined: no bypass; latency is always 1 cycle.

## Structure
- Shared package fetch_pkg holds:
  - the NOP_INSTR constant (32'h00000013)
  - the fetch_entry_t struct {pc, instr}
  - the default queue depth constant
- One sub-module, if_fq_storage: DEPTH×2·XLEN register array with write port (we, waddr, wdata) and asynchronous read (raddr → rdata).
- Pointers, count, handshake logic and bypass stay in if_fetch_queue.

## Test plan
- Streaming: reset, then i_fetch_valid and i_ready held at 1 with PC 0x0, 0x4, 0x8… → o_valid from cycle 2, o_pc follows in order with 1-cycle lag, o_count stays 1, o_pc_wr_en stays 1.
- Fill and stall: i_ready = 0 for 6 cycles with DEPTH = 4 → o_count saturates at 4, o_pc_wr_en = 0 from the cycle count reaches 4, entries 0x0–0xC retained; then i_ready = 1 → drains in order, with a simultaneous push on the first full-pop cycle.
- Flush: flush with 3 entries queued and i_fetch_valid = 1 → next cycle o_count = 0, o_valid = 0, o_instr = 0x00000013; the following push of PC 0x100 appears alone.
- Clock enable: i_clk_en = 0 for 3 cycles with pending push and pop → count, outputs and pointers unchanged; the flush asserted in that window is ignored.
- Reset mid-operation: i_rst asserted while the queue is full → next cycle o_count = 0, o_valid = 0, o_pc = 0, o_pc_wr_en = 1.
- Bypass, IF_FETCH_QUEUE_BYPASS_EN only: empty queue, push PC 0x40 with i_ready = 1 → o_valid = 1 and o_pc = 0x40 in the same cycle, o_count stays 0.
